ahb_sram_ws: RTL and testbench

Parametrised AHB-Lite SRAM slave, the successor to the single-cycle SRAM model. Adds:
- proper address/data-phase pipelining
- byte/halfword/word writes via HSIZE lane strobes
- a configurable wait-state counter driving HREADYOUT
- a two-cycle ERROR response for out-of-range or misaligned accesses

It sits on the AHB-Lite interconnect as instruction/data RAM behind the CPU's bus decoder.

---
 rtl/ahb_sram_ws.sv | 148 ++++++++++++++
 tb/tb_ahb_sram_ws.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with pipelined address/data phases, byte-lane writes,
// configurable wait states and a two-cycle ERROR response.
module ahb_sram_ws #(
    parameter int    DEPTH_WORDS = 8192,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [AW-1:0] idx_reg;
    logic [1:0]    lo_reg;
    logic [2:0]    size_reg;
    logic          write_reg;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_mem_reg;
    logic [31:0]   fwd_data_reg;
    logic [3:0]    fwd_lane_reg;

    logic          can_accept, accept, req_err;
    logic          size_bad, misaligned, out_of_range;
    logic          wr_commit, rd_en, fwd_hit;
    logic [AW-1:0] haddr_idx, rd_idx;
    logic [3:0]    strb;
    logic [31:0]   rd_word;
    logic          unused_bits;

    assign unused_bits = HTRANS[0];

    // An address phase can only be taken while this slave is driving HREADYOUT high.
    assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
    assign haddr_idx  = HADDR[AW+1:2];

    assign size_bad     = (HSIZE > 3'b010);
    assign misaligned   = ((HSIZE == 3'b001) && HADDR[0]) ||
                          ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
    assign out_of_range = ({2'b00, HADDR[31:2]} >= 32'(DEPTH_WORDS));
    assign req_err      = size_bad | misaligned | out_of_range;

    // Writes retire in the DATA cycle; a reset in that cycle drops the write.
    assign wr_commit = (state_reg == ST_DATA) && write_reg && !HRESET;
    // The RAM is read on the edge that enters DATA so data is ready in that cycle.
    assign rd_en     = (state_next == ST_DATA);
    assign rd_idx    = (state_reg == ST_WAIT) ? idx_reg : haddr_idx;
    assign fwd_hit   = wr_commit && rd_en && (rd_idx == idx_reg);

    // Lane strobes from the captured size/offset, and per-lane bypass of forwarded write data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign strb[gi] = (size_reg == 3'b000) ? (lo_reg == 2'(gi)) :
                              (size_reg == 3'b001) ? (lo_reg[1] == 1'(gi / 2)) : 1'b1;
            assign rd_word[gi*8 +: 8] = fwd_lane_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                         : rd_mem_reg[gi*8 +: 8];
        end
    endgenerate

    // Next-state and wait-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_WAIT: begin
                if (cnt_reg == 4'd0) state_next = ST_DATA;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WS_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
        endcase
    end

    // State register and address-phase capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            lo_reg    <= '0;
            size_reg  <= '0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= haddr_idx;
                lo_reg    <= HADDR[1:0];
                size_reg  <= HSIZE;
                write_reg <= HWRITE;
            end
        end
    end

    // RAM: byte-enabled synchronous write and registered read.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
        if (rd_en) rd_mem_reg <= mem[rd_idx];
    end

    // Bypass registers so a read right behind a write to the same word sees the new lanes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_lane_reg <= '0;
            fwd_data_reg <= '0;
        end else if (rd_en) begin
            fwd_lane_reg <= fwd_hit ? strb : 4'b0000;
            fwd_data_reg <= HWDATA;
        end
    end

    assign HREADYOUT = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
    assign HRESP     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
    assign HRDATA    = ((state_reg == ST_DATA) && !write_reg) ? rd_word : 32'h0;
endmodule

// File: tb/tb_ahb_sram_ws.sv
// Self-checking bench for ahb_sram_ws: three instances (0, 3 and 2 wait states)
// share one bus driver; a transfer-level model predicts every data-phase cycle.
module tb_ahb_sram_ws;
    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset, hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          cur;

    logic [31:0] rd0, rd1, rd2, dut_rd;
    logic        ro0, ro1, ro2, rs0, rs1, rs2, dut_ro, dut_rs, hready;

    assign dut_rd = (cur == 0) ? rd0 : (cur == 1) ? rd1 : rd2;
    assign dut_ro = (cur == 0) ? ro0 : (cur == 1) ? ro1 : ro2;
    assign dut_rs = (cur == 0) ? rs0 : (cur == 1) ? rs1 : rs2;
    assign hready = dut_ro;

    ahb_sram_ws #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && (cur == 0)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));
    ahb_sram_ws #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && (cur == 1)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));
    ahb_sram_ws #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && (cur == 2)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

    // One expected data-phase cycle.
    typedef struct {
        bit          rdy;
        bit          resp;
        logic [31:0] data;
        bit          pin_en;
        logic [31:0] pin;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [int];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 0;

    function automatic exp_t mk(bit rdy, bit resp, logic [31:0] data,
                                bit pin_en, logic [31:0] pin, string nm);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.data = data;
        e.pin_en = pin_en; e.pin = pin; e.nm = nm;
        return e;
    endfunction

    // Compare process: every cycle the selected DUT's outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "idle");
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_tests++;
            if (dut_ro !== e.rdy) begin
                n_fail++;
                $display("FAIL %s HREADYOUT got %b expected %b", e.nm, dut_ro, e.rdy);
            end
            n_tests++;
            if (dut_rs !== e.resp) begin
                n_fail++;
                $display("FAIL %s HRESP got %b expected %b", e.nm, dut_rs, e.resp);
            end
            n_tests++;
            if (dut_rd !== e.data) begin
                n_fail++;
                $display("FAIL %s HRDATA got %h expected %h", e.nm, dut_rd, e.data);
            end
            if (e.pin_en) begin
                n_tests++;
                if (dut_rd !== e.pin) begin
                    n_fail++;
                    $display("FAIL %s literal HRDATA got %h expected %h", e.nm, dut_rd, e.pin);
                end
            end
            if (exp_q.size() == 0 && e.nm != "idle")
                $display("[TB] inst %0d %s done", cur, e.nm);
        end
    end

    // Drive one address phase, wait for acceptance, then queue the model's
    // prediction of its data phase.
    task automatic issue(input logic [31:0] a, input bit w, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [1:0] tr,
                         input bit pin_en, input logic [31:0] pin,
                         input string nm, input bit abort);
        int guard;
        bit err;
        int ws;
        int key;
        int nb;
        int base;
        logic [31:0] v;
        hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
        guard = 0;
        while (hready !== 1'b1) begin
            if (guard == 64) begin
                $display("FAIL %s accept timeout HREADYOUT=%b expected 1", nm, hready);
                $fatal(1, "bus hung");
            end
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        if (tr[1] == 1'b0) return;
        err = (sz > 3'd2) || (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0) ||
              (a / 4 >= DEPTH);
        if (err) begin
            exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, nm));
            exp_q.push_back(mk(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, nm));
            return;
        end
        ws  = (cur == 1) ? 3 : (cur == 2) ? 2 : 0;
        key = cur * DEPTH + int'(a / 4);
        repeat (ws) exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, nm));
        if (w) begin
            if (!abort) begin
                nb   = 1 << sz;
                base = int'(a % 4) & ~(nb - 1);
                v    = mdl.exists(key) ? mdl[key] : 32'h0;
                for (int b = base; b < base + nb; b++) v[b*8 +: 8] = wd[b*8 +: 8];
                mdl[key] = v;
            end
            exp_q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, nm));
        end else begin
            exp_q.push_back(mk(1'b1, 1'b0, mdl.exists(key) ? mdl[key] : 32'h0,
                               pin_en, pin, nm));
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      input string nm);
        issue(a, 1'b1, sz, wd, 2'b10, 1'b0, 32'h0, nm, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] pin, input string nm);
        issue(a, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, pin, nm, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            if (guard == 64) begin
                $display("FAIL drain timeout pending %0d expected 0", exp_q.size());
                $fatal(1, "drain hung");
            end
            @(posedge clk); #1;
            guard++;
        end
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; cur = 0;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Zero wait states: basic write/read, lanes, errors, forwarding.
        cur = 0;
        wr(32'h10, 3'd2, 32'hDEADBEEF, "w_deadbeef");
        rd(32'h10, 32'hDEADBEEF, "r_deadbeef");
        wr(32'h10, 3'd2, 32'h00000000, "w_zero");
        wr(32'h11, 3'd0, 32'h0000AA00, "w_byte_aa");
        rd(32'h10, 32'h0000AA00, "r_byte_aa");
        wr(32'h12, 3'd1, 32'h12340000, "w_half_1234");
        rd(32'h10, 32'h1234AA00, "r_half_1234");
        wr(32'h00, 3'd2, 32'h11111111, "w_word0");
        drain();
        issue(32'h02, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, "err_word_mis", 1'b0);
        issue(32'h01, 1'b1, 3'd1, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, "err_half_mis", 1'b0);
        issue(32'h00, 1'b1, 3'd3, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, "err_size", 1'b0);
        issue(DEPTH * 4, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, "err_range", 1'b0);
        rd(32'h00, 32'h11111111, "r_after_err");
        rd(32'h10, 32'h1234AA00, "r_after_err2");
        wr(32'h40, 3'd2, 32'h55667788, "w_fwd_word");
        rd(32'h40, 32'h55667788, "r_fwd_word");
        wr(32'h43, 3'd0, 32'h99000000, "w_fwd_byte");
        rd(32'h40, 32'h99667788, "r_fwd_byte");
        issue(32'h40, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, "idle_sel", 1'b0);
        issue(32'h40, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, "busy_sel", 1'b0);
        rd(32'h40, 32'h99667788, "r_after_idle");
        drain();

        // Three wait states, including back-to-back reads.
        cur = 1;
        wr(32'h20, 3'd2, 32'hCAFEF00D, "w3_cafe");
        wr(32'h24, 3'd2, 32'h01234567, "w3_0123");
        rd(32'h20, 32'hCAFEF00D, "r3_cafe");
        rd(32'h24, 32'h01234567, "r3_0123");
        rd(32'h20, 32'hCAFEF00D, "r3_cafe2");
        issue(32'h22, 1'b0, 3'd2, 32'h0, 2'b10, 1'b0, 32'h0, "err3_mis", 1'b0);
        drain();

        // Two wait states with a reset landing in the wait of a write.
        cur = 2;
        wr(32'h30, 3'd2, 32'h0BADF00D, "w2_base");
        rd(32'h30, 32'h0BADF00D, "r2_base");
        drain();
        issue(32'h30, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, "w2_abort", 1'b1);
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "post_reset"));
        drain();
        rd(32'h30, 32'h0BADF00D, "r2_after_reset");
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
